axis_frame_fifo_64: RTL



---
 rtl/axis_frame_fifo_64.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axis_frame_fifo_64.sv
// Store-and-forward AXI-Stream frame FIFO: a frame is released downstream only after its
// last beat arrives clean; bad frames and frames larger than the whole buffer are discarded.
module axis_frame_fifo_64 #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,

    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        NORMAL = 1'b0,
        DROP   = 1'b1
    } wrState_e;

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0] wrPtrCur_q, wrPtrCur_d;
    logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
    wrState_e            state_q, state_d;

    logic                overflow_q, overflow_d;
    logic                badFrame_q, badFrame_d;
    logic                goodFrame_q, goodFrame_d;

    logic                  outValid_q, outValid_d;
    logic                  outLast_q, outLast_d;
    logic [KEEP_WIDTH-1:0] outKeep_q, outKeep_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;

    logic empty;
    logic fullCur;
    logic inAccept;
    logic memWrite;
    logic readLoad;

    assign empty    = (wrPtr_q == rdPtr_q);
    assign fullCur  = (wrPtrCur_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]) &&
                      (wrPtrCur_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]);

    // With nothing committed, a full buffer can only mean the current frame is oversize,
    // so the beat is taken (and dropped) instead of stalling forever.
    assign input_axis_tready = !fullCur || (state_q == DROP) || empty;
    assign inAccept          = input_axis_tvalid && input_axis_tready;
    assign readLoad          = !empty && (!outValid_q || output_axis_tready);

    always_comb begin
        wrPtr_d     = wrPtr_q;
        wrPtrCur_d  = wrPtrCur_q;
        state_d     = state_q;
        overflow_d  = 1'b0;
        badFrame_d  = 1'b0;
        goodFrame_d = 1'b0;
        memWrite    = 1'b0;
        if (inAccept) begin
            if (state_q == DROP) begin
                if (input_axis_tlast) begin
                    state_d = NORMAL;
                end
            end else if (fullCur) begin
                wrPtrCur_d = wrPtr_q;
                overflow_d = 1'b1;
                if (!input_axis_tlast) begin
                    state_d = DROP;
                end
            end else begin
                memWrite   = 1'b1;
                wrPtrCur_d = wrPtrCur_q + PTR_ONE;
                if (input_axis_tlast) begin
                    if (input_axis_tuser) begin
                        wrPtrCur_d = wrPtr_q;
                        badFrame_d = 1'b1;
                    end else begin
                        wrPtr_d     = wrPtrCur_q + PTR_ONE;
                        goodFrame_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdPtr_d    = rdPtr_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outKeep_d  = outKeep_q;
        outData_d  = outData_q;
        if (readLoad) begin
            {outLast_d, outKeep_d, outData_d} = mem[rdPtr_q[ADDR_WIDTH-1:0]];
            outValid_d = 1'b1;
            rdPtr_d    = rdPtr_q + PTR_ONE;
        end else if (output_axis_tready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem[wrPtrCur_q[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tkeep, input_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            wrPtrCur_q  <= '0;
            rdPtr_q     <= '0;
            state_q     <= NORMAL;
            overflow_q  <= 1'b0;
            badFrame_q  <= 1'b0;
            goodFrame_q <= 1'b0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            outKeep_q   <= '0;
            outData_q   <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            wrPtrCur_q  <= wrPtrCur_d;
            rdPtr_q     <= rdPtr_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            badFrame_q  <= badFrame_d;
            goodFrame_q <= goodFrame_d;
            outValid_q  <= outValid_d;
            outLast_q   <= outLast_d;
            outKeep_q   <= outKeep_d;
            outData_q   <= outData_d;
        end
    end

    assign output_axis_tdata  = outData_q;
    assign output_axis_tkeep  = outKeep_q;
    assign output_axis_tvalid = outValid_q;
    assign output_axis_tlast  = outLast_q;
    assign output_axis_tuser  = 1'b0;
    assign overflow           = overflow_q;
    assign bad_frame          = badFrame_q;
    assign good_frame         = goodFrame_q;

endmodule
